// File: rtl/uart_mem_loader.sv
// uart_mem_loader: 8N1 UART receiver plus frame parser that streams bytes into imem/dmem.
// Latency: each data byte is written one cycle after its stop-bit sample; done_o follows the checksum byte by one cycle.
// Backpressure: none; at most one write per 10*ClksPerBit cycles, so every received byte is written immediately.
// Ports: clk/reset (async active-low), rx_i serial in; debug_* byte write stream;
//        cpu_hold_o core hold, done_o good-frame pulse, error_o sticky error.
module uart_mem_loader #(
  parameter int ClksPerBit    = 174,
  parameter int AddrWidth     = 12,
  parameter int TimeoutCycles = 2_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_i,
  output logic                 debug_o,
  output logic                 debug_imem_o,
  output logic                 debug_dmem_o,
  output logic [AddrWidth-1:0] debug_addr_o,
  output logic [7:0]           debug_data_o,
  output logic                 cpu_hold_o,
  output logic                 done_o,
  output logic                 error_o
);

  localparam int CW = $clog2(ClksPerBit);
  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam logic [CW-1:0] FullLast = CW'(ClksPerBit - 1);
  localparam logic [CW-1:0] HalfLast = CW'(ClksPerBit / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    S_IDLE, S_TARGET, S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM
  } state_t;

  // ---------------- RX front end ----------------
  logic            rx_meta, rx_sync, rx_prev;
  rx_state_t       rx_state, rx_next;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_byte;
  logic            rx_tick, byte_valid, frame_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // The start bit is checked at half a bit; all later samples are a full bit apart.
  assign rx_tick = (rx_cnt == ((rx_state == RX_START) ? HalfLast : FullLast));

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
      RX_START: if (rx_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = (rx_state == RX_STOP) && rx_tick && rx_sync;
    frame_err  = (rx_state == RX_STOP) && rx_tick && !rx_sync;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_byte  <= '0;
    end else begin
      rx_state <= rx_next;
      if (rx_state == RX_IDLE || rx_tick || rx_next != rx_state) rx_cnt <= '0;
      else                                                       rx_cnt <= rx_cnt + CW'(1);
      if (rx_state == RX_IDLE) rx_bit <= '0;
      else if (rx_state == RX_DATA && rx_tick) begin
        rx_bit  <= rx_bit + 3'd1;
        rx_byte <= {rx_sync, rx_byte[7:1]};
      end
    end
  end

  // ---------------- Frame parser ----------------
  state_t          state, next;
  logic [TW-1:0]   tcount;
  logic            timeout, bv;
  logic            sync_ok, wr, csum_ok, fail;
  logic            target;
  logic [7:0]      addr_lo, len_lo, csum;
  logic [15:0]     len, idx;
  logic [AddrWidth-1:0] base;

  // A timeout seen in the same cycle as a byte wins; the byte is discarded.
  assign timeout = (state != S_IDLE) && (tcount == TW'(TimeoutCycles));
  assign bv      = byte_valid && !timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    if (timeout || frame_err) next = S_IDLE;
    else if (bv) begin
      case (state)
        S_IDLE:    if (rx_byte == 8'hA5) next = S_TARGET;
        S_TARGET:  next = (rx_byte[7:1] == 7'd0) ? S_ADDR_LO : S_IDLE;
        S_ADDR_LO: next = S_ADDR_HI;
        S_ADDR_HI: next = S_LEN_LO;
        S_LEN_LO:  next = S_LEN_HI;
        S_LEN_HI:  next = ({rx_byte, len_lo} == 16'd0) ? S_CSUM : S_DATA;
        S_DATA:    if (idx == len - 16'd1) next = S_CSUM;
        S_CSUM:    next = S_IDLE;
        default:   next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sync_ok = (state == S_IDLE) && bv && (rx_byte == 8'hA5);
    wr      = (state == S_DATA) && bv;
    csum_ok = (state == S_CSUM) && bv && (rx_byte == csum);
    fail    = timeout || frame_err
            || ((state == S_TARGET) && bv && (rx_byte[7:1] != 7'd0))
            || ((state == S_CSUM) && bv && (rx_byte != csum));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      debug_o      <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      cpu_hold_o   <= 1'b0;
      debug_addr_o <= '0;
      debug_data_o <= '0;
      tcount       <= '0;
      target       <= 1'b0;
      addr_lo      <= '0;
      len_lo       <= '0;
      len          <= '0;
      idx          <= '0;
      csum         <= '0;
      base         <= '0;
    end else begin
      debug_o <= wr;
      done_o  <= csum_ok;
      if (fail) begin
        error_o    <= 1'b1;
        cpu_hold_o <= 1'b0;
      end else if (csum_ok) begin
        cpu_hold_o <= 1'b0;
      end else if (sync_ok) begin
        error_o    <= 1'b0;
        cpu_hold_o <= 1'b1;
      end

      if (state == S_IDLE || byte_valid) tcount <= '0;
      else if (!timeout)                 tcount <= tcount + TW'(1);

      if (bv) begin
        case (state)
          S_TARGET:  target  <= rx_byte[0];
          S_ADDR_LO: addr_lo <= rx_byte;
          S_ADDR_HI: base    <= AddrWidth'({rx_byte, addr_lo});
          S_LEN_LO:  len_lo  <= rx_byte;
          S_LEN_HI: begin
            len  <= {rx_byte, len_lo};
            idx  <= '0;
            csum <= '0;
          end
          S_DATA: begin
            // Address wraps naturally at the memory size.
            debug_addr_o <= base + AddrWidth'(idx);
            debug_data_o <= rx_byte;
            csum         <= csum + rx_byte;
            idx          <= idx + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign debug_imem_o = debug_o & ~target;
  assign debug_dmem_o = debug_o & target;

endmodule

// File: tb/tb_uart_mem_loader.sv
module tb_uart_mem_loader;
  localparam int CPB = 8;
  localparam int AW  = 12;
  localparam int TO  = 300;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx = 1'b1;
  logic          debug_o, debug_imem_o, debug_dmem_o, cpu_hold_o, done_o, error_o;
  logic [AW-1:0] debug_addr_o;
  logic [7:0]    debug_data_o;

  typedef struct packed {
    logic          dmem;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] tx_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  uart_mem_loader #(.ClksPerBit(CPB), .AddrWidth(AW), .TimeoutCycles(TO)) dut (
    .clk(clk), .reset(reset), .rx_i(rx),
    .debug_o(debug_o), .debug_imem_o(debug_imem_o), .debug_dmem_o(debug_dmem_o),
    .debug_addr_o(debug_addr_o), .debug_data_o(debug_data_o),
    .cpu_hold_o(cpu_hold_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  // Scoreboard side: every write strobe pops the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (done_o) done_cnt++;
    if (debug_o) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", debug_addr_o, debug_data_o);
      end else begin
        e = exp_q.pop_front();
        if ({debug_dmem_o, debug_imem_o, debug_addr_o, debug_data_o} !== {e.dmem, ~e.dmem, e.addr, e.data}) begin
          n_fail++;
          $display("FAIL write: got dmem=%b imem=%b addr=%h data=%h, required dmem=%b imem=%b addr=%h data=%h",
                   debug_dmem_o, debug_imem_o, debug_addr_o, debug_data_o, e.dmem, ~e.dmem, e.addr, e.data);
        end
      end
      n_checks++;
      if (cpu_hold_o !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_during_write: got %b, required 1", cpu_hold_o);
      end
    end
  end

  task automatic push_wr(input logic dmem, input int addr, input logic [7:0] data);
    wr_t w;
    w.dmem = dmem;
    w.addr = AW'(addr);
    w.data = data;
    exp_q.push_back(w);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_q;
    while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({debug_o, debug_imem_o, debug_dmem_o, debug_addr_o, debug_data_o, cpu_hold_o, done_o, error_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dbg=%b addr=%h data=%h hold=%b done=%b err=%b, required all 0",
               debug_o, debug_addr_o, debug_data_o, cpu_hold_o, done_o, error_o);
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_imem;
    int d0 = done_cnt;
    logic [7:0] d[3] = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) push_wr(1'b0, 12'h010 + i, d[i]);
    send_byte(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (cpu_hold_o !== 1'b1) begin n_fail++; $display("FAIL imem_hold_after_sync: got %b, required 1", cpu_hold_o); end
    tx_q = '{8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h66};
    send_q();
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL imem_done: got %0d pulses, required 1", done_cnt - d0); end
    n_checks++;
    if ({cpu_hold_o, error_o} !== 2'b00) begin n_fail++; $display("FAIL imem_hold_err: got hold=%b err=%b, required 0 0", cpu_hold_o, error_o); end
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL imem_writes: got %0d missing, required 0", exp_q.size()); end
  endtask

  task automatic test_dmem_wrap;
    int d0 = done_cnt;
    logic [7:0] d[3] = '{8'hAA, 8'hBB, 8'hCC};
    for (int i = 0; i < 3; i++) push_wr(1'b1, (12'hFFE + i) % 4096, d[i]);
    tx_q = '{8'hA5, 8'h01, 8'hFE, 8'h0F, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'h31};
    send_q();
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL wrap_done: got %0d pulses, required 1", done_cnt - d0); end
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL wrap_writes: got %0d missing, required 0", exp_q.size()); end
  endtask

  task automatic test_bad_csum;
    int d0 = done_cnt;
    logic [7:0] d[3] = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) push_wr(1'b0, 12'h010 + i, d[i]);
    tx_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h67};
    send_q();
    repeat (4) @(negedge clk);
    n_checks++;
    if ({error_o, cpu_hold_o} !== 2'b10) begin n_fail++; $display("FAIL csum_err_hold: got err=%b hold=%b, required 1 0", error_o, cpu_hold_o); end
    n_checks++;
    if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL csum_no_done: got %0d pulses, required 0", done_cnt - d0); end
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL csum_writes: got %0d missing, required 0", exp_q.size()); end
  endtask

  task automatic test_bad_target;
    int d0 = done_cnt;
    tx_q = '{8'hA5, 8'h02};
    send_q();
    repeat (4) @(negedge clk);
    n_checks++;
    if ({error_o, cpu_hold_o} !== 2'b10) begin n_fail++; $display("FAIL target_err: got err=%b hold=%b, required 1 0", error_o, cpu_hold_o); end
    send_byte(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    n_checks++;
    if ({error_o, cpu_hold_o} !== 2'b01) begin n_fail++; $display("FAIL target_clear: got err=%b hold=%b, required 0 1", error_o, cpu_hold_o); end
    push_wr(1'b1, 12'h200, 8'h5A);
    tx_q = '{8'h01, 8'h00, 8'h02, 8'h01, 8'h00, 8'h5A, 8'h5A};
    send_q();
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL target_recover_done: got %0d pulses, required 1", done_cnt - d0); end
  endtask

  task automatic test_timeout_framing;
    int d0 = done_cnt;
    push_wr(1'b0, 12'h000, 8'h11);
    tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h11};
    send_q();
    repeat (TO - 60) @(negedge clk);
    n_checks++;
    if ({error_o, cpu_hold_o} !== 2'b01) begin n_fail++; $display("FAIL timeout_early: got err=%b hold=%b, required 0 1", error_o, cpu_hold_o); end
    repeat (100) @(negedge clk);
    n_checks++;
    if ({error_o, cpu_hold_o} !== 2'b10) begin n_fail++; $display("FAIL timeout_fire: got err=%b hold=%b, required 1 0", error_o, cpu_hold_o); end
    push_wr(1'b0, 12'h100, 8'h77);
    tx_q = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h77};
    send_q();
    send_byte(8'h88, 1'b0);
    repeat (30) @(negedge clk);
    n_checks++;
    if ({error_o, cpu_hold_o} !== 2'b10) begin n_fail++; $display("FAIL framing_err: got err=%b hold=%b, required 1 0", error_o, cpu_hold_o); end
    n_checks++;
    if (exp_q.size() !== 0 || done_cnt - d0 !== 0) begin
      n_fail++; $display("FAIL framing_writes: got missing=%0d done=%0d, required 0 0", exp_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_data;
    int d0 = done_cnt;
    push_wr(1'b0, 12'h020, 8'h11);
    tx_q = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h04, 8'h00, 8'h11};
    send_q();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({debug_o, debug_imem_o, debug_dmem_o, debug_addr_o, debug_data_o, cpu_hold_o, done_o, error_o} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got dbg=%b addr=%h data=%h hold=%b done=%b err=%b, required all 0",
               debug_o, debug_addr_o, debug_data_o, cpu_hold_o, done_o, error_o);
    end
    reset = 1'b1;
    repeat (100) @(negedge clk);
    n_checks++;
    if ({error_o, cpu_hold_o} !== 2'b00 || done_cnt - d0 !== 0 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL midreset_after: got err=%b hold=%b done=%0d missing=%0d, required 0 0 0 0",
                         error_o, cpu_hold_o, done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_glitch;
    int d0 = done_cnt;
    send_byte(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (150) @(negedge clk);
    n_checks++;
    if ({error_o, cpu_hold_o} !== 2'b01) begin n_fail++; $display("FAIL glitch_state: got err=%b hold=%b, required 0 1", error_o, cpu_hold_o); end
    push_wr(1'b0, 12'h040, 8'h3C);
    tx_q = '{8'h00, 8'h40, 8'h00, 8'h01, 8'h00, 8'h3C, 8'h3C};
    send_q();
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 !== 1 || error_o !== 1'b0) begin
      n_fail++; $display("FAIL glitch_frame: got done=%0d err=%b, required 1 0", done_cnt - d0, error_o);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_imem();
    test_dmem_wrap();
    test_bad_csum();
    test_bad_target();
    test_timeout_framing();
    test_reset_mid_data();
    test_glitch();
    repeat (10) @(negedge clk);
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL final_scoreboard: got %0d missing, required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
